// File: rtl/logic_unit_arbiter_if.sv
// rtl/logic_unit_arbiter_if.sv - request/result bundle between requesters, arbiter and consumer
interface logic_unit_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       req_i;
    logic [N_REQ-1:0]       op_i;
    logic [N_REQ*WIDTH-1:0] a_i;
    logic [N_REQ*WIDTH-1:0] b_i;
    logic [N_REQ-1:0]       gnt_o;
    logic                   res_valid_o;
    logic                   res_ready_i;
    logic [ID_W-1:0]        res_id_o;
    logic [WIDTH-1:0]       res_c_o;
    logic [WIDTH-1:0]       res_d_o;

    modport slave (
        input  req_i, op_i, a_i, b_i, res_ready_i,
        output gnt_o, res_valid_o, res_id_o, res_c_o, res_d_o
    );

    modport master (
        output req_i, op_i, a_i, b_i, res_ready_i,
        input  gnt_o, res_valid_o, res_id_o, res_c_o, res_d_o
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin sharing of one AND/OR logic unit with a registered result slot
module logic_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    logic_unit_arbiter_if.slave    bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_e;

    slot_e            slot_q, slot_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] d_q, d_d;

    logic             found;
    logic             issue;
    logic [ID_W-1:0]  win_id;
    logic             op_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    int               idx;

    // First requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        op_sel = 1'b0;
        a_sel  = '0;
        b_sel  = '0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && bus.req_i[idx]) begin
                found  = 1'b1;
                win_id = ID_W'(idx);
                op_sel = bus.op_i[idx];
                a_sel  = bus.a_i[idx*WIDTH +: WIDTH];
                b_sel  = bus.b_i[idx*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        slot_d = slot_q;
        ptr_d  = ptr_q;
        id_d   = id_q;
        c_d    = c_q;
        d_d    = d_q;
        issue  = rst_n && found && (slot_q == EMPTY || bus.res_ready_i);
        bus.gnt_o = '0;
        if (issue) begin
            bus.gnt_o[win_id] = 1'b1;
            slot_d = FULL;
            id_d   = win_id;
            c_d    = op_sel ? (a_sel | b_sel) : (a_sel & b_sel);
            d_d    = a_sel | b_sel;
            ptr_d  = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
        end else if (slot_q == FULL && bus.res_ready_i) begin
            slot_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= EMPTY;
            ptr_q  <= '0;
            id_q   <= '0;
            c_q    <= '0;
            d_q    <= '0;
        end else begin
            slot_q <= slot_d;
            ptr_q  <= ptr_d;
            id_q   <= id_d;
            c_q    <= c_d;
            d_q    <= d_d;
        end
    end

    assign bus.res_valid_o = (slot_q == FULL);
    assign bus.res_id_o    = id_q;
    assign bus.res_c_o     = c_q;
    assign bus.res_d_o     = d_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - directed and randomized checks of logic_unit_arbiter against a reference model
module tb_logic_unit_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   mism = 0;

    logic_unit_arbiter_if #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();

    logic_unit_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit       m_valid;
    int       m_id, m_ptr;
    int       m_c, m_d;
    logic [N-1:0] last_gnt;
    int       waitc [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_ptr = 0; m_c = 0; m_d = 0;
    endtask

    function automatic int pick_winner();
        for (int k = 0; k < N; k++)
            if (bus.req_i[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    // One clock: check grant before the edge, advance the model, check the slot after it.
    task automatic step();
        int  w;
        bit  iss;
        logic [N-1:0] eg;
        int  a, b;
        #1;
        w   = pick_winner();
        iss = (w >= 0) && (!m_valid || bus.res_ready_i);
        eg  = '0;
        if (iss) eg[w] = 1'b1;
        last_gnt = bus.gnt_o;
        chk("gnt", 32'(bus.gnt_o), 32'(eg));
        @(posedge clk);
        if (iss) begin
            a = int'(bus.a_i[w*W +: W]);
            b = int'(bus.b_i[w*W +: W]);
            m_c = bus.op_i[w] ? (a | b) : (a & b);
            m_d = a | b;
            m_id = w;
            m_valid = 1;
            m_ptr = (w + 1) % N;
        end else if (m_valid && bus.res_ready_i) begin
            m_valid = 0;
        end
        #1;
        chk("valid", 32'(bus.res_valid_o), 32'(m_valid));
        chk("id",    32'(bus.res_id_o),    32'(m_id));
        chk("c",     32'(bus.res_c_o),     32'(m_c));
        chk("d",     32'(bus.res_d_o),     32'(m_d));
    endtask

    task automatic set_req(input int k, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op_i[k] = op;
        bus.a_i[k*W +: W] = a;
        bus.b_i[k*W +: W] = b;
    endtask

    initial begin
        logic [N-1:0] rr_exp [6];
        logic [31:0] sv_id, sv_c, sv_d;
        bit stalled;

        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rst_n = 1'b0;
        bus.req_i = 4'b0001;
        bus.op_i = '0;
        bus.a_i = '0;
        bus.b_i = '0;
        bus.res_ready_i = 1'b1;
        model_reset();
        for (int k = 0; k < N; k++) set_req(k, 1'b0, 8'(k * 17 + 5), 8'(k * 29 + 3));
        repeat (2) @(posedge clk);
        #3;
        chk("rst_gnt",   32'(bus.gnt_o), 0);
        chk("rst_valid", 32'(bus.res_valid_o), 0);
        chk("rst_c",     32'(bus.res_c_o), 0);
        rst_n = 1'b1;

        step();
        chk("post_rst_gnt", 32'(last_gnt), 32'h1);

        bus.req_i = 4'b0100;
        set_req(2, 1'b0, 8'hF0, 8'h3C);
        step();
        chk("single_gnt", 32'(last_gnt), 32'h4);
        chk("single_id", 32'(bus.res_id_o), 2);
        chk("single_and", 32'(bus.res_c_o), 32'h30);
        chk("single_d", 32'(bus.res_d_o), 32'hFC);
        set_req(2, 1'b1, 8'hF0, 8'h3C);
        step();
        chk("single_or", 32'(bus.res_c_o), 32'hFC);

        bus.req_i = 4'b1000;
        step();
        bus.req_i = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_gnt", 32'(last_gnt), 32'(rr_exp[i]));
        end

        bus.req_i = 4'b1000;
        step();
        bus.req_i = 4'b0110;
        step();
        chk("skip_gnt1", 32'(last_gnt), 32'h2);
        step();
        chk("skip_gnt2", 32'(last_gnt), 32'h4);
        bus.req_i = 4'b0001;
        step();
        chk("wrap_gnt0", 32'(last_gnt), 32'h1);

        bus.res_ready_i = 1'b0;
        bus.req_i = 4'b0011;
        sv_id = 32'(bus.res_id_o); sv_c = 32'(bus.res_c_o); sv_d = 32'(bus.res_d_o);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_gnt", 32'(last_gnt), 0);
            chk("stall_hold", {8'(bus.res_id_o), 8'(bus.res_c_o), 8'(bus.res_d_o)},
                {sv_id[7:0], sv_c[7:0], sv_d[7:0]});
        end
        bus.res_ready_i = 1'b1;
        step();
        chk("unstall_gnt", 32'(last_gnt), 32'h2);
        chk("unstall_id", 32'(bus.res_id_o), 1);

        bus.req_i = '0;
        sv_c = 32'(bus.res_c_o);
        step();
        chk("drain_valid", 32'(bus.res_valid_o), 0);
        chk("drain_hold", 32'(bus.res_c_o), sv_c);
        bus.req_i = 4'b1111;
        step();
        chk("drain_ptr", 32'(last_gnt), 32'h4);

        bus.res_ready_i = 1'b0;
        bus.req_i = 4'b0011;
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.res_valid_o), 0);
        chk("mid_rst_gnt", 32'(bus.gnt_o), 0);
        chk("mid_rst_data", {8'(bus.res_id_o), 8'(bus.res_c_o), 8'(bus.res_d_o)}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.res_ready_i = 1'b1;
        bus.req_i = '0;
        step();

        for (int k = 0; k < N; k++) waitc[k] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (!bus.req_i[k] && ($urandom % 3 != 0)) begin
                    bus.req_i[k] = 1'b1;
                    set_req(k, 1'($urandom), 8'($urandom), 8'($urandom));
                    waitc[k] = 0;
                end
            end
            bus.res_ready_i = ($urandom % 4 != 0);
            stalled = m_valid && !bus.res_ready_i;
            for (int k = 0; k < N; k++)
                if (bus.req_i[k] && !stalled) waitc[k]++;
            step();
            for (int k = 0; k < N; k++) begin
                if (last_gnt[k]) begin
                    chk("fair_wait", 32'(waitc[k] <= N), 1);
                    bus.req_i[k] = 1'b0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 2-output logic unit among N_REQ requesters.
  - Output C = AND or OR of the operands, selected per request.
  - Output D = OR of the operands, always.
- Round-robin arbitration, one grant per cycle.
- Single registered result slot with valid/ready backpressure.
- Sits between the requesting control blocks and the downstream consumer of the logic-unit results.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- WIDTH, 8, operand/result width in bits.
- ID_W, $clog2(N_REQ), width of requester index.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_i  input  N_REQ  per-requester request; held high until granted.
- op_i  input  N_REQ  per-requester C function: 0 = AND, 1 = OR.
- a_i  input  N_REQ*WIDTH  operand A; requester k occupies bits [k*WIDTH +: WIDTH].
- b_i  input  N_REQ*WIDTH  operand B, same packing as a_i.
- gnt_o  output  N_REQ  one-hot grant; combinational; operands of granted requester captured at the same edge.
- res_valid_o  output  1  result slot holds a valid result.
- res_ready_i  input  1  consumer accepts the result this cycle.
- res_id_o  output  ID_W  index of the requester that owns the result.
- res_c_o  output  WIDTH  A&B if captured op=0, A|B if op=1.
- res_d_o  output  WIDTH  A|B.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - res_valid_o=0, res_id_o=0, res_c_o=0, res_d_o=0.
  - Round-robin pointer ptr=0.
  - gnt_o=0 while rst_n low.
- Slot state, derived from res_valid_o:
  - EMPTY (res_valid_o=0).
  - FULL (res_valid_o=1).
- Issue condition:
  - issue = |req_i & (EMPTY | (FULL & res_ready_i)).
  - Back-to-back: a FULL slot that is being consumed can be refilled in the same cycle.
- Winner selection:
  - Winner = first k with req_i[k]=1, searching ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1 (modulo wrap).
  - gnt_o = onehot(winner) when issue, else all zeros. Never more than one bit set.
- At an issue edge:
  - res_id_o ← winner.
  - res_c_o ← op_i[winner] ? (A|B) : (A&B).
  - res_d_o ← A|B.
  - res_valid_o ← 1.
  - ptr ← (winner+1) mod N_REQ, wrapping from N_REQ-1 to 0.
- Latency: grant cycle → result visible on the next cycle (1 cycle).
- Consume without refill: FULL & res_ready_i & ~|req_i → res_valid_o ← 0. Data outputs hold their last values.
- Stall: FULL & ~res_ready_i.
  - gnt_o=0.
  - Result registers and ptr hold, stable.
  - Requests stay pending.
- ptr changes only on an issue. No request, or a stall, leaves ptr unchanged.
- Requester rules:
  - A requester may deassert req only after its gnt.
  - It may re-request in the cycle immediately after its grant.
  - Under continuous contention, a requester is granted at most N_REQ cycles after requesting (cycles counted while the slot is not stalled).
- Reset mid-operation: a pending result is dropped; outputs return to reset values immediately.
- Sustained throughput: 1 result per cycle while res_ready_i=1.

Test Plan:
- Reset check: rst_n low mid-stream with res_valid_o=1 → res_valid_o=0, gnt_o=0, outputs 0 asynchronously. After release with req_i=4'b0001 → gnt_o=4'b0001.
- Single request (WIDTH=8): req_i=4'b0100, op_i[2]=0, a=8'hF0, b=8'h3C, res_ready_i=1 → gnt_o=4'b0100. Next cycle: res_valid_o=1, res_id_o=2, res_c_o=8'h30, res_d_o=8'hFC. Same request with op_i[2]=1 → res_c_o=8'hFC.
- Round-robin fairness: req_i=4'b1111 held, res_ready_i=1 → grants 0,1,2,3,0,1 on consecutive cycles; res_id_o follows one cycle later.
- Pointer wrap and skip: after a grant to 3, req_i=4'b0110 → grant 1, then 2. After the grant to 2, req_i=4'b0001 → grant 0.
- Backpressure: res_ready_i=0 with FULL slot and req_i=4'b0011 for 5 cycles → gnt_o=0 and res_c_o/res_d_o/res_id_o stable throughout. Raise res_ready_i → grant to the ptr-ordered winner in that same cycle; new result the next cycle.
- Drain: FULL, res_ready_i=1, req_i=0 → res_valid_o=0 next cycle, data held, ptr unchanged (next req_i=4'b1111 grants the stored ptr).
